// File: rtl/commit_ctrl_pkg.sv
// Shared widths and encodings for the in-order commit sequencer.
// Head kinds and commit-FSM state codes live here so the RTL and bench agree.
package commit_ctrl_pkg;

  localparam int REG_LEN  = 5;
  localparam int ROB_LEN  = 5;
  localparam int DATA_LEN = 32;

  typedef enum logic [1:0] {
    KIND_REG    = 2'b00,
    KIND_STORE  = 2'b01,
    KIND_BRANCH = 2'b10,
    KIND_HALT   = 2'b11
  } kind_e;

  typedef enum logic [1:0] {
    CS_IDLE       = 2'b00,
    CS_STORE_WAIT = 2'b01,
    CS_RECOVER    = 2'b10,
    CS_HALT       = 2'b11
  } state_e;

endpackage

// File: rtl/commit_ctrl_if.sv
// Bundle between the ROB head, regfile unlock port, LSB and the commit sequencer.
// master = commit_ctrl side, slave = ROB/regfile/LSB side.
interface commit_ctrl_if;
  import commit_ctrl_pkg::*;

  logic                ready;
  logic                head_valid;
  logic                head_done;
  kind_e               head_kind;
  logic [REG_LEN-1:0]  head_rd;
  logic [ROB_LEN-1:0]  head_robpos;
  logic [DATA_LEN-1:0] head_val;
  logic                head_mispredict;
  logic [DATA_LEN-1:0] head_target;
  logic                st_done;

  logic                rob_pop;
  logic                unlock;
  logic [REG_LEN-1:0]  unlock_rd;
  logic [ROB_LEN-1:0]  unlock_robpos;
  logic [DATA_LEN-1:0] unlock_val;
  logic                st_commit;
  logic [ROB_LEN-1:0]  st_robpos;
  logic                flush;
  logic [DATA_LEN-1:0] flush_pc;
  logic                halted;
  logic [31:0]         commit_cnt;

  modport master (
    input  ready, head_valid, head_done, head_kind, head_rd, head_robpos,
           head_val, head_mispredict, head_target, st_done,
    output rob_pop, unlock, unlock_rd, unlock_robpos, unlock_val,
           st_commit, st_robpos, flush, flush_pc, halted, commit_cnt
  );

  modport slave (
    output ready, head_valid, head_done, head_kind, head_rd, head_robpos,
           head_val, head_mispredict, head_target, st_done,
    input  rob_pop, unlock, unlock_rd, unlock_robpos, unlock_val,
           st_commit, st_robpos, flush, flush_pc, halted, commit_cnt
  );

endinterface

// File: rtl/commit_ctrl.sv
// In-order commit sequencer: retires at most one ROB head entry per decision,
// driving regfile unlock, store commit handshake, mispredict flush and halt.
module commit_ctrl
  import commit_ctrl_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  commit_ctrl_if.master bus
);

  state_e              state_q, state_d;
  logic                rob_pop_q, rob_pop_d;
  logic                unlock_q, unlock_d;
  logic [REG_LEN-1:0]  unlock_rd_q, unlock_rd_d;
  logic [ROB_LEN-1:0]  unlock_robpos_q, unlock_robpos_d;
  logic [DATA_LEN-1:0] unlock_val_q, unlock_val_d;
  logic                st_commit_q, st_commit_d;
  logic [ROB_LEN-1:0]  st_robpos_q, st_robpos_d;
  logic                flush_q, flush_d;
  logic [DATA_LEN-1:0] flush_pc_q, flush_pc_d;
  logic                halted_q, halted_d;
  logic [31:0]         commit_cnt_q, commit_cnt_d;
  logic                commit_ok;

  // The pop guard keeps a head that the ROB has not yet removed from retiring twice.
  assign commit_ok = bus.ready && bus.head_valid && bus.head_done && !rob_pop_q;

  always_comb begin
    // NOTE: every _d gets a default (hold for state/payloads, 0 for pulses) before
    // the case below, so no path leaves a signal unassigned and infers a latch.
    state_d         = state_q;
    rob_pop_d       = 1'b0;
    unlock_d        = 1'b0;
    flush_d         = 1'b0;
    unlock_rd_d     = unlock_rd_q;
    unlock_robpos_d = unlock_robpos_q;
    unlock_val_d    = unlock_val_q;
    st_commit_d     = st_commit_q;
    st_robpos_d     = st_robpos_q;
    flush_pc_d      = flush_pc_q;
    halted_d        = halted_q;
    commit_cnt_d    = commit_cnt_q;

    unique case (state_q)
      CS_IDLE: begin
        if (commit_ok) begin
          unique case (bus.head_kind)
            KIND_REG, KIND_BRANCH: begin
              rob_pop_d    = 1'b1;
              commit_cnt_d = commit_cnt_q + 32'd1;
              if (bus.head_rd != '0) begin
                unlock_d        = 1'b1;
                unlock_rd_d     = bus.head_rd;
                unlock_robpos_d = bus.head_robpos;
                unlock_val_d    = bus.head_val;
              end
              if (bus.head_kind == KIND_BRANCH && bus.head_mispredict) begin
                flush_d    = 1'b1;
                flush_pc_d = bus.head_target;
                state_d    = CS_RECOVER;
              end
            end
            KIND_STORE: begin
              st_commit_d = 1'b1;
              st_robpos_d = bus.head_robpos;
              state_d     = CS_STORE_WAIT;
            end
            KIND_HALT: begin
              rob_pop_d    = 1'b1;
              commit_cnt_d = commit_cnt_q + 32'd1;
              halted_d     = 1'b1;
              state_d      = CS_HALT;
            end
          endcase
        end
      end
      CS_STORE_WAIT: begin
        if (bus.ready && bus.st_done) begin
          st_commit_d  = 1'b0;
          rob_pop_d    = 1'b1;
          commit_cnt_d = commit_cnt_q + 32'd1;
          state_d      = CS_IDLE;
        end
      end
      CS_RECOVER: begin
        if (bus.ready) state_d = CS_IDLE;
      end
      CS_HALT: begin
        state_d = CS_HALT;
      end
    endcase
  end

  // Async reset clears every output at once; the LSB relies on st_commit
  // dropping without a clock to discard an in-flight store.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= CS_IDLE;
      rob_pop_q       <= 1'b0;
      unlock_q        <= 1'b0;
      unlock_rd_q     <= '0;
      unlock_robpos_q <= '0;
      unlock_val_q    <= '0;
      st_commit_q     <= 1'b0;
      st_robpos_q     <= '0;
      flush_q         <= 1'b0;
      flush_pc_q      <= '0;
      halted_q        <= 1'b0;
      commit_cnt_q    <= '0;
    end else begin
      state_q         <= state_d;
      rob_pop_q       <= rob_pop_d;
      unlock_q        <= unlock_d;
      unlock_rd_q     <= unlock_rd_d;
      unlock_robpos_q <= unlock_robpos_d;
      unlock_val_q    <= unlock_val_d;
      st_commit_q     <= st_commit_d;
      st_robpos_q     <= st_robpos_d;
      flush_q         <= flush_d;
      flush_pc_q      <= flush_pc_d;
      halted_q        <= halted_d;
      commit_cnt_q    <= commit_cnt_d;
    end
  end

  assign bus.rob_pop       = rob_pop_q;
  assign bus.unlock        = unlock_q;
  assign bus.unlock_rd     = unlock_rd_q;
  assign bus.unlock_robpos = unlock_robpos_q;
  assign bus.unlock_val    = unlock_val_q;
  assign bus.st_commit     = st_commit_q;
  assign bus.st_robpos     = st_robpos_q;
  assign bus.flush         = flush_q;
  assign bus.flush_pc      = flush_pc_q;
  assign bus.halted        = halted_q;
  assign bus.commit_cnt    = commit_cnt_q;

endmodule

// File: tb/tb_commit_ctrl.sv
// Directed, table-driven bench for commit_ctrl: each record is one clock of
// head inputs plus the hand-computed registered outputs after that edge.
module tb_commit_ctrl;
  import commit_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;

  commit_ctrl_if bus ();

  commit_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rdy, vld, dn;
    kind_e       kind;
    logic [4:0]  rd, rob;
    logic [31:0] val;
    logic        mis;
    logic [31:0] tgt;
    logic        sd;
    logic        e_pop, e_unl;
    logic [4:0]  e_rd, e_rob;
    logic [31:0] e_val;
    logic        e_st;
    logic [4:0]  e_strob;
    logic        e_fl;
    logic [31:0] e_pc;
    logic        e_halt;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(
    input logic rdy, input logic vld, input logic dn, input kind_e k,
    input logic [4:0] rd, input logic [4:0] rob, input logic [31:0] val,
    input logic mis, input logic [31:0] tgt, input logic sd,
    input logic e_pop, input logic e_unl, input logic [4:0] e_rd,
    input logic [4:0] e_rob, input logic [31:0] e_val, input logic e_st,
    input logic [4:0] e_strob, input logic e_fl, input logic [31:0] e_pc,
    input logic e_halt, input logic [31:0] e_cnt);
    vec_t v;
    v.rdy = rdy; v.vld = vld; v.dn = dn; v.kind = k; v.rd = rd; v.rob = rob;
    v.val = val; v.mis = mis; v.tgt = tgt; v.sd = sd;
    v.e_pop = e_pop; v.e_unl = e_unl; v.e_rd = e_rd; v.e_rob = e_rob;
    v.e_val = e_val; v.e_st = e_st; v.e_strob = e_strob; v.e_fl = e_fl;
    v.e_pc = e_pc; v.e_halt = e_halt; v.e_cnt = e_cnt;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    bus.ready           = v.rdy;
    bus.head_valid      = v.vld;
    bus.head_done       = v.dn;
    bus.head_kind       = v.kind;
    bus.head_rd         = v.rd;
    bus.head_robpos     = v.rob;
    bus.head_val        = v.val;
    bus.head_mispredict = v.mis;
    bus.head_target     = v.tgt;
    bus.st_done         = v.sd;
  endtask

  task automatic check_all(input vec_t v, input string tag);
    check({tag, ".rob_pop"},       32'(bus.rob_pop),       32'(v.e_pop));
    check({tag, ".unlock"},        32'(bus.unlock),        32'(v.e_unl));
    check({tag, ".unlock_rd"},     32'(bus.unlock_rd),     32'(v.e_rd));
    check({tag, ".unlock_robpos"}, 32'(bus.unlock_robpos), 32'(v.e_rob));
    check({tag, ".unlock_val"},    bus.unlock_val,         v.e_val);
    check({tag, ".st_commit"},     32'(bus.st_commit),     32'(v.e_st));
    check({tag, ".st_robpos"},     32'(bus.st_robpos),     32'(v.e_strob));
    check({tag, ".flush"},         32'(bus.flush),         32'(v.e_fl));
    check({tag, ".flush_pc"},      bus.flush_pc,           v.e_pc);
    check({tag, ".halted"},        32'(bus.halted),        32'(v.e_halt));
    check({tag, ".commit_cnt"},    bus.commit_cnt,         v.e_cnt);
  endtask

  // Drive on the falling edge, let the DUT sample on the rising edge, compare 1 ns later.
  task automatic step(input vec_t v, input string tag);
    @(negedge clk);
    drive(v);
    @(posedge clk);
    #1;
    check_all(v, tag);
  endtask

  initial begin
    vec_t idle, zero;
    idle = mk(1,0,0,KIND_REG,0,0,0,0,0,0, 0,0,0,0,0,0,0,0,0,0,0);
    zero = idle;

    //            rdy vld dn kind        rd rob val           mis tgt    sd | pop unl rd rob val           st strob fl pc     halt cnt
    // register commit, then held head must not pop again
    vq.push_back(mk(1,1,1,KIND_REG,    5, 3, 32'hDEADBEEF, 0, 0,     0,  1,1, 5, 3, 32'hDEADBEEF, 0, 0, 0, 0,     0, 1));
    vq.push_back(mk(1,1,1,KIND_REG,    5, 3, 32'hDEADBEEF, 0, 0,     0,  0,0, 5, 3, 32'hDEADBEEF, 0, 0, 0, 0,     0, 1));
    // rd = 0: pop and count, no unlock
    vq.push_back(mk(1,1,1,KIND_REG,    0, 4, 32'h11,       0, 0,     0,  1,0, 5, 3, 32'hDEADBEEF, 0, 0, 0, 0,     0, 2));
    vq.push_back(mk(1,0,0,KIND_REG,    0, 0, 0,            0, 0,     0,  0,0, 5, 3, 32'hDEADBEEF, 0, 0, 0, 0,     0, 2));
    // ready low for 3 cycles with a committable head, then release
    vq.push_back(mk(0,1,1,KIND_REG,    6, 5, 32'h22,       0, 0,     0,  0,0, 5, 3, 32'hDEADBEEF, 0, 0, 0, 0,     0, 2));
    vq.push_back(mk(0,1,1,KIND_REG,    6, 5, 32'h22,       0, 0,     0,  0,0, 5, 3, 32'hDEADBEEF, 0, 0, 0, 0,     0, 2));
    vq.push_back(mk(0,1,1,KIND_REG,    6, 5, 32'h22,       0, 0,     0,  0,0, 5, 3, 32'hDEADBEEF, 0, 0, 0, 0,     0, 2));
    vq.push_back(mk(1,1,1,KIND_REG,    6, 5, 32'h22,       0, 0,     0,  1,1, 6, 5, 32'h22,       0, 0, 0, 0,     0, 3));
    vq.push_back(mk(1,0,0,KIND_REG,    0, 0, 0,            0, 0,     0,  0,0, 6, 5, 32'h22,       0, 0, 0, 0,     0, 3));
    // head not done stalls
    vq.push_back(mk(1,1,0,KIND_REG,    7, 6, 32'h44,       0, 0,     0,  0,0, 6, 5, 32'h22,       0, 0, 0, 0,     0, 3));
    // store handshake; st_done while ready low is not taken
    vq.push_back(mk(1,1,1,KIND_STORE,  0, 7, 0,            0, 0,     0,  0,0, 6, 5, 32'h22,       1, 7, 0, 0,     0, 3));
    vq.push_back(mk(1,1,1,KIND_STORE,  0, 7, 0,            0, 0,     0,  0,0, 6, 5, 32'h22,       1, 7, 0, 0,     0, 3));
    vq.push_back(mk(0,1,1,KIND_STORE,  0, 7, 0,            0, 0,     1,  0,0, 6, 5, 32'h22,       1, 7, 0, 0,     0, 3));
    vq.push_back(mk(1,1,1,KIND_STORE,  0, 7, 0,            0, 0,     0,  0,0, 6, 5, 32'h22,       1, 7, 0, 0,     0, 3));
    vq.push_back(mk(1,1,1,KIND_STORE,  0, 7, 0,            0, 0,     1,  1,0, 6, 5, 32'h22,       0, 7, 0, 0,     0, 4));
    vq.push_back(mk(1,1,1,KIND_STORE,  0, 7, 0,            0, 0,     0,  0,0, 6, 5, 32'h22,       0, 7, 0, 0,     0, 4));
    // stray st_done in IDLE ignored
    vq.push_back(mk(1,0,0,KIND_REG,    0, 0, 0,            0, 0,     1,  0,0, 6, 5, 32'h22,       0, 7, 0, 0,     0, 4));
    // mispredict: unlock+pop+flush together, next head ignored, then resume
    vq.push_back(mk(1,1,1,KIND_BRANCH, 1, 8, 32'h104,      1, 32'h200, 0, 1,1, 1, 8, 32'h104,      0, 7, 1, 32'h200, 0, 5));
    vq.push_back(mk(1,1,1,KIND_REG,    9, 9, 32'h33,       0, 0,     0,  0,0, 1, 8, 32'h104,      0, 7, 0, 32'h200, 0, 5));
    vq.push_back(mk(1,1,1,KIND_REG,    9, 9, 32'h33,       0, 0,     0,  1,1, 9, 9, 32'h33,       0, 7, 0, 32'h200, 0, 6));
    vq.push_back(mk(1,0,0,KIND_REG,    0, 0, 0,            0, 0,     0,  0,0, 9, 9, 32'h33,       0, 7, 0, 32'h200, 0, 6));
    // correctly predicted branch with rd = 0
    vq.push_back(mk(1,1,1,KIND_BRANCH, 0,10, 0,            0, 32'h300, 0, 1,0, 9, 9, 32'h33,       0, 7, 0, 32'h200, 0, 7));
    vq.push_back(mk(1,0,0,KIND_REG,    0, 0, 0,            0, 0,     0,  0,0, 9, 9, 32'h33,       0, 7, 0, 32'h200, 0, 7));
    // halt is absorbing
    vq.push_back(mk(1,1,1,KIND_HALT,   0,11, 0,            0, 0,     0,  1,0, 9, 9, 32'h33,       0, 7, 0, 32'h200, 1, 8));
    vq.push_back(mk(1,1,1,KIND_REG,    3,12, 32'h55,       0, 0,     0,  0,0, 9, 9, 32'h33,       0, 7, 0, 32'h200, 1, 8));
    vq.push_back(mk(1,1,1,KIND_REG,    3,12, 32'h55,       0, 0,     0,  0,0, 9, 9, 32'h33,       0, 7, 0, 32'h200, 1, 8));
    vq.push_back(mk(1,1,1,KIND_REG,    3,12, 32'h55,       0, 0,     0,  0,0, 9, 9, 32'h33,       0, 7, 0, 32'h200, 1, 8));

    reset = 1'b1;
    drive(idle);
    #12;
    check_all(zero, "reset");
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vq.size(); i++) step(vq[i], $sformatf("v%0d", i));

    // async reset leaves HALT and clears everything, then commits work again
    @(negedge clk);
    drive(idle);
    reset = 1'b1;
    #1;
    check_all(zero, "halt_rst");
    @(negedge clk);
    reset = 1'b0;
    step(mk(1,1,1,KIND_REG, 2, 1, 32'h77, 0, 0, 0, 1,1, 2, 1, 32'h77, 0, 0, 0, 0, 0, 1), "post_halt");
    step(mk(1,0,0,KIND_REG, 0, 0, 0,      0, 0, 0, 0,0, 2, 1, 32'h77, 0, 0, 0, 0, 0, 1), "post_halt_idle");

    // async reset in STORE_WAIT drops st_commit without a clock edge
    step(mk(1,1,1,KIND_STORE, 0, 9, 0, 0, 0, 0, 0,0, 2, 1, 32'h77, 1, 9, 0, 0, 0, 1), "st2_issue");
    step(mk(1,1,1,KIND_STORE, 0, 9, 0, 0, 0, 0, 0,0, 2, 1, 32'h77, 1, 9, 0, 0, 0, 1), "st2_wait");
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_all(zero, "st_arst");
    drive(idle);
    @(negedge clk);
    reset = 1'b0;
    // state must be back in IDLE: a register head commits without st_done
    step(mk(1,1,1,KIND_REG, 3, 2, 32'h88, 0, 0, 0, 1,1, 3, 2, 32'h88, 0, 0, 0, 0, 0, 1), "after_st_arst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
